// File: rtl/pe_pkg.sv
// Shared definitions for the posit front-end: precision mode codes, lane
// geometry and the per-lane decode result.
// No ports (package).
package pe_pkg;

  localparam int PRECISION_CONFIG_L = 2;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;

  localparam int SEG_LEN  = 8;
  localparam int N_SEG    = 4;
  localparam int REGIME_W = 7;

  typedef struct packed {
    logic                       sign;
    logic                       zero;
    logic                       nar;
    logic signed [REGIME_W-1:0] regime;
    logic [5:0]                 shift;
  } lane_res_t;

  // Any encoding other than 16B/8B decodes as a full 32-bit word.
  function automatic logic [PRECISION_CONFIG_L-1:0] norm_mode(
    input logic [PRECISION_CONFIG_L-1:0] m
  );
    if (m == PRECISION_CONFIG_16B || m == PRECISION_CONFIG_8B) return m;
    return PRECISION_CONFIG_32B;
  endfunction

  // k is the regime run length, w the lane width; zero/NaR bypass the regime.
  function automatic lane_res_t lane_decode(
    input logic [5:0] k,
    input logic       r0,
    input logic       zero,
    input logic       nar,
    input logic       sign,
    input logic [5:0] w
  );
    lane_res_t r;
    r.sign = sign;
    r.zero = zero;
    r.nar  = nar;
    if (zero || nar) begin
      r.regime = '0;
      r.shift  = w;
    end else begin
      r.regime = r0 ? ({1'b0, k} - 7'd1) : (7'd0 - {1'b0, k});
      // sign + run + terminator, capped at lane width (no terminator on a full run)
      r.shift  = ((k + 6'd2) > w) ? w : (k + 6'd2);
    end
    return r;
  endfunction

endpackage

// File: rtl/posit_regime_decode_stage_if.sv
// Handshake/data bundle of the regime decode stage.
//   in_valid/in_ready/in_data/in_mode     : input beat
//   out_valid/out_ready/out_*             : decoded beat
// master = beat source / result sink, slave = the decode stage.
interface posit_regime_decode_stage_if;
  import pe_pkg::*;

  logic                                    in_valid;
  logic                                    in_ready;
  logic [31:0]                             in_data;
  logic [PRECISION_CONFIG_L-1:0]           in_mode;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [31:0]                             out_mag;
  logic [N_SEG-1:0][4:0]                   out_shift_val;
  logic                                    out_full_shift;
  logic [PRECISION_CONFIG_L-1:0]           out_mode;
  logic [N_SEG-1:0][REGIME_W-1:0]          out_regime;
  logic [N_SEG-1:0]                        out_sign;
  logic [N_SEG-1:0]                        out_zero;
  logic [N_SEG-1:0]                        out_nar;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_mag, out_shift_val, out_full_shift,
           out_mode, out_regime, out_sign, out_zero, out_nar
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_mag, out_shift_val, out_full_shift,
           out_mode, out_regime, out_sign, out_zero, out_nar
  );

endinterface

// File: rtl/posit_regime_decode_stage_run_length_count.sv
// Counts how many bits, starting at the MSB of vec, equal lead_bit (0..LEN).
//   vec      : input vector
//   lead_bit : bit value whose leading run is counted
//   cnt      : run length
module run_length_count #(
  parameter int LEN = 8
) (
  input  logic [LEN-1:0]             vec,
  input  logic                       lead_bit,
  output logic [$clog2(LEN+1)-1:0]   cnt
);
  localparam int CNT_W = $clog2(LEN + 1);

  logic done;

  always_comb begin
    cnt  = '0;
    done = 1'b0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (!done) begin
        if (vec[i] == lead_bit) cnt = cnt + CNT_W'(1);
        else                    done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_regime_decode_stage.sv
// Two-stage posit regime decoder feeding the decomposable left shifter.
// S1 negates negative lanes to magnitude; S2 counts the regime run per lane
// and registers regime, flags and per-segment shift amounts.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of posit_regime_decode_stage_if
module posit_regime_decode_stage
  import pe_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  posit_regime_decode_stage_if.slave  bus
);

  logic                            s1_valid, s2_valid, s1_adv, s2_adv;
  logic [31:0]                     s1_mag, s1_mag_d;
  logic [N_SEG-1:0]                s1_sign, s1_sign_d;
  logic [PRECISION_CONFIG_L-1:0]   s1_mode, in_mode_n, s1_mode_n;

  logic [N_SEG-1:0]                seg_top, seg_lead;
  logic [N_SEG-1:0][SEG_LEN-1:0]   seg_vec;
  logic [N_SEG-1:0][3:0]           seg_cnt;
  lane_res_t                       res [N_SEG];
  logic [5:0]                      k;

  logic [31:0]                     s2_mag;
  logic [N_SEG-1:0][4:0]           s2_shift, s2_shift_d;
  logic                            s2_full, s2_full_d;
  logic [PRECISION_CONFIG_L-1:0]   s2_mode;
  logic [N_SEG-1:0][REGIME_W-1:0]  s2_regime, s2_regime_d;
  logic [N_SEG-1:0]                s2_sign, s2_zero, s2_nar;
  logic [N_SEG-1:0]                s2_sign_d, s2_zero_d, s2_nar_d;

  // A stage may load whenever the stage ahead of it frees up this cycle.
  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;

  assign in_mode_n = norm_mode(bus.in_mode);
  assign s1_mode_n = norm_mode(s1_mode);

  always_comb begin
    s1_mag_d  = bus.in_data;
    s1_sign_d = {N_SEG{bus.in_data[31]}};
    if (in_mode_n == PRECISION_CONFIG_8B) begin
      for (int j = 0; j < 4; j++) begin
        s1_sign_d[j] = bus.in_data[8*j+7];
        if (bus.in_data[8*j+7]) s1_mag_d[8*j+:8] = ~bus.in_data[8*j+:8] + 8'd1;
      end
    end else if (in_mode_n == PRECISION_CONFIG_16B) begin
      for (int j = 0; j < 2; j++) begin
        s1_sign_d[2*j]   = bus.in_data[16*j+15];
        s1_sign_d[2*j+1] = bus.in_data[16*j+15];
        if (bus.in_data[16*j+15]) s1_mag_d[16*j+:16] = ~bus.in_data[16*j+:16] + 16'd1;
      end
    end else begin
      if (bus.in_data[31]) s1_mag_d = ~bus.in_data + 32'd1;
    end
  end

  // The top segment of each lane holds the sign bit; it is replaced by a copy
  // of the first body bit so the segment count includes one extra bit.
  always_comb begin
    seg_top  = 4'b1000;
    seg_lead = {N_SEG{s1_mag[30]}};
    if (s1_mode_n == PRECISION_CONFIG_8B) begin
      seg_top = 4'b1111;
      for (int i = 0; i < N_SEG; i++) seg_lead[i] = s1_mag[8*i+6];
    end else if (s1_mode_n == PRECISION_CONFIG_16B) begin
      seg_top  = 4'b1010;
      seg_lead = {{2{s1_mag[30]}}, {2{s1_mag[14]}}};
    end
    for (int i = 0; i < N_SEG; i++)
      seg_vec[i] = seg_top[i] ? {s1_mag[8*i+6], s1_mag[8*i+:7]} : s1_mag[8*i+:8];
  end

  for (genvar g = 0; g < N_SEG; g++) begin : g_rlc
    run_length_count #(.LEN(SEG_LEN)) u_rlc (
      .vec      (seg_vec[g]),
      .lead_bit (seg_lead[g]),
      .cnt      (seg_cnt[g])
    );
  end

  // Runs continue into the next lower segment only while segments are uniform.
  always_comb begin
    k = '0;
    for (int i = 0; i < N_SEG; i++) res[i] = '0;
    case (s1_mode_n)
      PRECISION_CONFIG_8B: begin
        for (int i = 0; i < N_SEG; i++) begin
          k = 6'(seg_cnt[i]) - 6'd1;
          res[i] = lane_decode(k, seg_lead[i], s1_mag[8*i+:8] == 8'h00,
                               s1_mag[8*i+:8] == 8'h80, s1_sign[i], 6'd8);
        end
      end
      PRECISION_CONFIG_16B: begin
        for (int j = 0; j < 2; j++) begin
          k = 6'(seg_cnt[2*j+1]) - 6'd1;
          if (seg_cnt[2*j+1] == 4'd8) k = k + 6'(seg_cnt[2*j]);
          res[2*j+1] = lane_decode(k, seg_lead[2*j+1], s1_mag[16*j+:16] == 16'h0000,
                                   s1_mag[16*j+:16] == 16'h8000, s1_sign[2*j+1], 6'd16);
          res[2*j]   = res[2*j+1];
        end
      end
      default: begin
        k = 6'(seg_cnt[3]) - 6'd1;
        if (seg_cnt[3] == 4'd8) begin
          k = k + 6'(seg_cnt[2]);
          if (seg_cnt[2] == 4'd8) begin
            k = k + 6'(seg_cnt[1]);
            if (seg_cnt[1] == 4'd8) k = k + 6'(seg_cnt[0]);
          end
        end
        res[3] = lane_decode(k, seg_lead[3], s1_mag == 32'h0,
                             s1_mag == 32'h8000_0000, s1_sign[3], 6'd32);
        for (int i = 0; i < 3; i++) res[i] = res[3];
      end
    endcase
  end

  always_comb begin
    s2_full_d = 1'b0;
    for (int i = 0; i < N_SEG; i++) begin
      s2_sign_d[i]   = res[i].sign;
      s2_zero_d[i]   = res[i].zero;
      s2_nar_d[i]    = res[i].nar;
      s2_regime_d[i] = res[i].regime;
      s2_shift_d[i]  = res[i].shift[4:0];
    end
    // A 32-bit shift does not fit the 5-bit shifter field; flag it instead.
    if (s1_mode_n == PRECISION_CONFIG_32B && res[3].shift[5]) begin
      s2_full_d  = 1'b1;
      s2_shift_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mag    <= '0;
      s1_sign   <= '0;
      s1_mode   <= '0;
      s2_valid  <= 1'b0;
      s2_mag    <= '0;
      s2_shift  <= '0;
      s2_full   <= 1'b0;
      s2_mode   <= '0;
      s2_regime <= '0;
      s2_sign   <= '0;
      s2_zero   <= '0;
      s2_nar    <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_mag    <= s1_mag;
          s2_shift  <= s2_shift_d;
          s2_full   <= s2_full_d;
          s2_mode   <= s1_mode;
          s2_regime <= s2_regime_d;
          s2_sign   <= s2_sign_d;
          s2_zero   <= s2_zero_d;
          s2_nar    <= s2_nar_d;
        end
      end
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_mag  <= s1_mag_d;
          s1_sign <= s1_sign_d;
          s1_mode <= bus.in_mode;
        end
      end
    end
  end

  assign bus.out_valid      = s2_valid;
  assign bus.out_mag        = s2_mag;
  assign bus.out_shift_val  = s2_shift;
  assign bus.out_full_shift = s2_full;
  assign bus.out_mode       = s2_mode;
  assign bus.out_regime     = s2_regime;
  assign bus.out_sign       = s2_sign;
  assign bus.out_zero       = s2_zero;
  assign bus.out_nar        = s2_nar;

endmodule

// File: tb/tb_posit_regime_decode_stage.sv
// Directed bench for posit_regime_decode_stage.
module tb_posit_regime_decode_stage;
  import pe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  posit_regime_decode_stage_if bus ();
  posit_regime_decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] M32 = PRECISION_CONFIG_32B;
  localparam logic [1:0] M16 = PRECISION_CONFIG_16B;
  localparam logic [1:0] M8  = PRECISION_CONFIG_8B;

  typedef struct {
    logic        valid;
    logic [31:0] mag;
    logic [19:0] sv;
    logic        full;
    logic [1:0]  mode;
    logic [27:0] rg;
    logic [3:0]  sign, zero, nar;
  } obs_t;

  function automatic obs_t sample();
    obs_t o;
    o.valid = bus.out_valid;
    o.mag   = bus.out_mag;
    o.sv    = bus.out_shift_val;
    o.full  = bus.out_full_shift;
    o.mode  = bus.out_mode;
    o.rg    = bus.out_regime;
    o.sign  = bus.out_sign;
    o.zero  = bus.out_zero;
    o.nar   = bus.out_nar;
    return o;
  endfunction

  // Single beat into an empty pipe with out_ready high; lat counts clock
  // edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic run_beat(input logic [31:0] d, input logic [1:0] m,
                          output obs_t o, output int lat);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_mode   = m;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    @(posedge clk); #1;
    lat = 2;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    o = sample();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = M32; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_mag !== 32'h0) begin failures++; $display("FAIL rst_mag got=%h exp=0", bus.out_mag); end
    checks++; if (bus.out_regime !== 28'h0 || bus.out_shift_val !== 20'h0 || bus.out_full_shift !== 1'b0)
      begin failures++; $display("FAIL rst_data got=%h/%h/%b exp=0", bus.out_regime, bus.out_shift_val, bus.out_full_shift); end
    checks++; if ({bus.out_sign, bus.out_zero, bus.out_nar} !== 12'h0)
      begin failures++; $display("FAIL rst_flags got=%h exp=0", {bus.out_sign, bus.out_zero, bus.out_nar}); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_32b();
    obs_t o; int lat;
    run_beat(32'h4000_0000, M32, o, lat);
    checks++; if (lat != 2 || o.valid !== 1'b1) begin failures++; $display("FAIL t32_latency got=%0d exp=2", lat); end
    checks++; if (o.mag !== 32'h4000_0000 || o.sign !== 4'h0) begin failures++; $display("FAIL t32_pos_mag got=%h/%h exp=40000000/0", o.mag, o.sign); end
    checks++; if (o.rg !== 28'h0 || o.sv !== {4{5'd3}} || o.full !== 1'b0 || o.mode !== M32)
      begin failures++; $display("FAIL t32_pos_dec got=%h/%h/%b/%0d exp=0/%h/0/0", o.rg, o.sv, o.full, o.mode, {4{5'd3}}); end
    run_beat(32'hC000_0000, M32, o, lat);
    checks++; if (o.mag !== 32'h4000_0000 || o.sign !== 4'hF) begin failures++; $display("FAIL t32_neg_mag got=%h/%h exp=40000000/f", o.mag, o.sign); end
    checks++; if (o.rg !== 28'h0 || o.sv !== {4{5'd3}}) begin failures++; $display("FAIL t32_neg_dec got=%h/%h exp=0/%h", o.rg, o.sv, {4{5'd3}}); end
    run_beat(32'h0000_0001, M32, o, lat);
    checks++; if (o.rg !== {4{7'h62}} || o.full !== 1'b1 || o.sv !== 20'h0)
      begin failures++; $display("FAIL t32_min got=%h/%b/%h exp=%h/1/0", o.rg, o.full, o.sv, {4{7'h62}}); end
    run_beat(32'h7FFF_FFFF, M32, o, lat);
    checks++; if (o.rg !== {4{7'h1E}} || o.full !== 1'b1 || o.sv !== 20'h0)
      begin failures++; $display("FAIL t32_max got=%h/%b/%h exp=%h/1/0", o.rg, o.full, o.sv, {4{7'h1E}}); end
    run_beat(32'h8000_0000, M32, o, lat);
    checks++; if (o.nar !== 4'hF || o.zero !== 4'h0 || o.rg !== 28'h0 || o.full !== 1'b1 || o.mag !== 32'h8000_0000)
      begin failures++; $display("FAIL t32_nar got=%h/%h/%h/%b/%h exp=f/0/0/1/80000000", o.nar, o.zero, o.rg, o.full, o.mag); end
    run_beat(32'h0000_0000, M32, o, lat);
    checks++; if (o.zero !== 4'hF || o.nar !== 4'h0 || o.rg !== 28'h0 || o.full !== 1'b1 || o.sv !== 20'h0)
      begin failures++; $display("FAIL t32_zero got=%h/%h/%h/%b/%h exp=f/0/0/1/0", o.zero, o.nar, o.rg, o.full, o.sv); end
    run_beat(32'h4000_0000, 2'd3, o, lat);
    checks++; if (o.sv !== {4{5'd3}} || o.full !== 1'b0 || o.mode !== 2'd3)
      begin failures++; $display("FAIL t32_undef_mode got=%h/%b/%0d exp=%h/0/3", o.sv, o.full, o.mode, {4{5'd3}}); end
  endtask

  task automatic test_8b();
    obs_t o; int lat;
    run_beat(32'h0080_7F01, M8, o, lat);
    checks++; if (o.rg !== {7'h00, 7'h00, 7'h06, 7'h7A} || o.sv !== {4{5'd8}} || o.full !== 1'b0)
      begin failures++; $display("FAIL t8_mix_dec got=%h/%h/%b exp=%h/%h/0", o.rg, o.sv, o.full, {7'h00, 7'h00, 7'h06, 7'h7A}, {4{5'd8}}); end
    checks++; if (o.zero !== 4'b1000 || o.nar !== 4'b0100 || o.sign !== 4'b0100 || o.mag !== 32'h0080_7F01)
      begin failures++; $display("FAIL t8_mix_flags got=%h/%h/%h/%h exp=8/4/4/00807f01", o.zero, o.nar, o.sign, o.mag); end
    run_beat(32'hFFC0_1002, M8, o, lat);
    checks++; if (o.mag !== 32'h0140_1002 || o.sign !== 4'b1100 || o.mode !== M8)
      begin failures++; $display("FAIL t8_neg_mag got=%h/%h/%0d exp=01401002/c/2", o.mag, o.sign, o.mode); end
    checks++; if (o.rg !== {7'h7A, 7'h00, 7'h7E, 7'h7B} || o.sv !== {5'd8, 5'd3, 5'd4, 5'd7})
      begin failures++; $display("FAIL t8_neg_dec got=%h/%h exp=%h/%h", o.rg, o.sv, {7'h7A, 7'h00, 7'h7E, 7'h7B}, {5'd8, 5'd3, 5'd4, 5'd7}); end
  endtask

  task automatic test_16b();
    obs_t o; int lat;
    run_beat(32'h3000_7000, M16, o, lat);
    checks++; if (o.rg !== {7'h7F, 7'h7F, 7'h02, 7'h02} || o.sv !== {5'd3, 5'd3, 5'd5, 5'd5} || o.full !== 1'b0)
      begin failures++; $display("FAIL t16_a got=%h/%h/%b exp=%h/%h/0", o.rg, o.sv, o.full, {7'h7F, 7'h7F, 7'h02, 7'h02}, {5'd3, 5'd3, 5'd5, 5'd5}); end
    run_beat(32'h3000_6000, M16, o, lat);
    checks++; if (o.rg !== {7'h7F, 7'h7F, 7'h01, 7'h01} || o.sv !== {5'd3, 5'd3, 5'd4, 5'd4} || o.mode !== M16)
      begin failures++; $display("FAIL t16_b got=%h/%h/%0d exp=%h/%h/1", o.rg, o.sv, o.mode, {7'h7F, 7'h7F, 7'h01, 7'h01}, {5'd3, 5'd3, 5'd4, 5'd4}); end
    run_beat(32'hFFFF_8000, M16, o, lat);
    checks++; if (o.mag !== 32'h0001_8000 || o.sign !== 4'hF || o.nar !== 4'b0011 || o.zero !== 4'h0)
      begin failures++; $display("FAIL t16_neg_flags got=%h/%h/%h/%h exp=00018000/f/3/0", o.mag, o.sign, o.nar, o.zero); end
    checks++; if (o.rg !== {7'h72, 7'h72, 7'h00, 7'h00} || o.sv !== {4{5'd16}} || o.full !== 1'b0)
      begin failures++; $display("FAIL t16_neg_dec got=%h/%h/%b exp=%h/%h/0", o.rg, o.sv, o.full, {7'h72, 7'h72, 7'h00, 7'h00}, {4{5'd16}}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    logic [1:0]  md [3];
    logic [31:0] em [3];
    logic [27:0] er [3];
    logic [19:0] es [3];
    obs_t cur, held;
    logic stalled, in_fire, out_fire, exp_rdy;
    int sent, got, occ, cyc;
    d[0] = 32'h4000_0000; md[0] = M32; em[0] = 32'h4000_0000; er[0] = 28'h0;                          es[0] = {4{5'd3}};
    d[1] = 32'h3000_6000; md[1] = M16; em[1] = 32'h3000_6000; er[1] = {7'h7F, 7'h7F, 7'h01, 7'h01}; es[1] = {5'd3, 5'd3, 5'd4, 5'd4};
    d[2] = 32'h0080_7F01; md[2] = M8;  em[2] = 32'h0080_7F01; er[2] = {7'h00, 7'h00, 7'h06, 7'h7A}; es[2] = {4{5'd8}};
    sent = 0; got = 0; occ = 0; cyc = 0; stalled = 1'b0;
    while (got < 3 && cyc < 40) begin
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.in_valid  = (sent < 3);
      if (sent < 3) begin bus.in_data = d[sent]; bus.in_mode = md[sent]; end
      #1;
      cur = sample();
      exp_rdy = !(occ == 2 && !bus.out_ready);
      checks++; if (bus.in_ready !== exp_rdy) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_rdy); end
      if (stalled) begin
        checks++;
        if (cur.valid !== 1'b1 || cur.mag !== held.mag || cur.rg !== held.rg || cur.sv !== held.sv || cur.mode !== held.mode)
          begin failures++; $display("FAIL b2b_stall_hold cyc=%0d got=%h/%h exp=%h/%h", cyc, cur.mag, cur.rg, held.mag, held.rg); end
      end
      in_fire  = bus.in_valid & bus.in_ready;
      out_fire = bus.out_valid & bus.out_ready;
      if (out_fire) begin
        checks++;
        if (cur.mag !== em[got] || cur.rg !== er[got] || cur.sv !== es[got] || cur.mode !== md[got])
          begin failures++; $display("FAIL b2b_beat%0d got=%h/%h/%h/%0d exp=%h/%h/%h/%0d", got, cur.mag, cur.rg, cur.sv, cur.mode, em[got], er[got], es[got], md[got]); end
        got++;
      end
      stalled = bus.out_valid & ~bus.out_ready;
      held = cur;
      @(posedge clk); #1;
      occ = occ + int'(in_fire) - int'(out_fire);
      if (in_fire) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    logic seen;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h4000_0000; bus.in_mode = M32;
    @(posedge clk); #1;
    bus.in_data = 32'h3000_6000; bus.in_mode = M16;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rstm_fill got=%b exp=1", bus.out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_mag !== 32'h0)
      begin failures++; $display("FAIL rstm_drop got=%b/%h exp=0/0", bus.out_valid, bus.out_mag); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstm_in_ready got=%b exp=1", bus.in_ready); end
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstm_ghost got=%b exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_32b();
    test_8b();
    test_16b();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
